// File: rtl/field_pkg.sv
// ============================================================================
// Module  : field_pkg
// Purpose : Shared geometry, types and address-to-slot mapping for the
//           field packer and the indexed field selector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package field_pkg;

  localparam int FIELD_W   = 3;
  localparam int NUM_SLOTS = 7;
  localparam int ADDR_W    = 5;
  localparam int ADDR_SPAN = 28;

  localparam int WORD_W = FIELD_W * NUM_SLOTS;
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  localparam logic [ADDR_W-1:0] CLEAR_ADDR = '1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [SLOT_W-1:0] slot_idx(input logic [ADDR_W-1:0] addr);
    return SLOT_W'(addr % ADDR_W'(NUM_SLOTS));
  endfunction

endpackage

`default_nettype wire

// File: rtl/field_slot_decode.sv
// ============================================================================
// Module  : field_slot_decode
// Purpose : Combinational decode of a slot address into a one-hot slot select
//           and data / clear / illegal classification.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module field_slot_decode
  import field_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_SLOTS-1:0] slot_oh,
  output logic                 is_data,
  output logic                 is_clear,
  output logic                 is_err
);

  always_comb begin
    is_data  = (addr < ADDR_W'(ADDR_SPAN));
    is_clear = (addr == CLEAR_ADDR);
    is_err   = !is_data && !is_clear;
    slot_oh  = '0;
    if (is_data) begin
      slot_oh = NUM_SLOTS'(1) << slot_idx(addr);
    end
  end

endmodule

`default_nettype wire

// File: rtl/field_packer.sv
// ============================================================================
// Module  : field_packer
// Purpose : Packs addressed 3-bit symbols into a 7-slot word and hands the
//           completed word downstream on a valid/ready handshake.
//           Optional counters enabled with FIELD_PACKER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module field_packer
  import field_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [FIELD_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic [NUM_SLOTS-1:0] slot_mask,
  output logic                 err_addr,
  output logic                 err_dup
`ifdef FIELD_PACKER_STATS_EN
  ,
  output logic [15:0]          word_count,
  output logic [7:0]           drop_count
`endif
);

  state_e               state_q, state_d;
  word_t                acc_q, acc_d;
  word_t                out_word_q, out_word_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_addr_q, err_addr_d;
  logic                 err_dup_q, err_dup_d;

  logic [NUM_SLOTS-1:0] slot_oh;
  logic                 is_data, is_clear, is_err;
  logic                 accept, wr_data, complete, out_hs;
  word_t                acc_wr;
  logic [NUM_SLOTS-1:0] mask_wr;

  field_slot_decode u_decode (
    .addr     (in_addr),
    .slot_oh  (slot_oh),
    .is_data  (is_data),
    .is_clear (is_clear),
    .is_err   (is_err)
  );

  // HOLD is entered exactly when a word sits in the output register.
  assign in_ready = (state_q == ST_FILL) || out_ready;
  assign accept   = in_valid && in_ready;
  assign wr_data  = accept && is_data;
  assign out_hs   = out_valid_q && out_ready;
  assign mask_wr  = mask_q | slot_oh;
  assign complete = wr_data && (&mask_wr);

  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_oh[k]) begin
        acc_wr[k*FIELD_W +: FIELD_W] = in_data;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    mask_d      = mask_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (accept && is_clear) begin
      acc_d  = '0;
      mask_d = '0;
    end else if (complete) begin
      out_word_d  = acc_wr;
      out_valid_d = 1'b1;
      acc_d       = '0;
      mask_d      = '0;
    end else if (wr_data) begin
      acc_d  = acc_wr;
      mask_d = mask_wr;
    end
    err_addr_d = accept && is_err;
    err_dup_d  = wr_data && |(mask_q & slot_oh);
    state_d    = out_valid_d ? ST_HOLD : ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      acc_q       <= '0;
      mask_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      err_addr_q  <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      err_addr_q  <= err_addr_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign slot_mask = mask_q;
  assign err_addr  = err_addr_q;
  assign err_dup   = err_dup_q;

`ifdef FIELD_PACKER_STATS_EN
  logic [15:0] word_count_q, word_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    word_count_d = word_count_q;
    drop_count_d = drop_count_q;
    if (out_hs) begin
      word_count_d = word_count_q + 16'd1;
    end
    if (err_addr_d && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign word_count = word_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/field_packer.md
Name: field_packer

Overview:
- Write-side counterpart of the indexed field selector: accepts 3-bit symbols tagged with a 5-bit slot address and packs them into a 21-bit word made of 7 slots.
- The address-to-slot mapping is the same one the selector decodes: slot = addr mod 7 for addr 0..27, and address 31 is a special code.
- Once all slots are written, the packed word is presented downstream on a valid/ready handshake. The block sits in front of the selector's b bus.

Parameters:
- FIELD_W, 3, width of one slot in bits.
- NUM_SLOTS, 7, number of slots per packed word.
- ADDR_W, 5, width of the slot address.
- ADDR_SPAN, 28, number of legal data addresses (0..ADDR_SPAN-1). Must be a multiple of NUM_SLOTS and below 2**ADDR_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream symbol valid.
- in_ready  output  1  block can accept a symbol.
- in_addr  input  ADDR_W  slot address.
- in_data  input  FIELD_W  symbol value.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts the word.
- out_word  output  FIELD_W*NUM_SLOTS  packed word. Slot k occupies bits [k*FIELD_W+FIELD_W-1 : k*FIELD_W].
- slot_mask  output  NUM_SLOTS  slots currently written in the accumulator.
- err_addr  output  1  one-cycle pulse: an accepted address was in ADDR_SPAN..2**ADDR_W-2.
- err_dup  output  1  one-cycle pulse: an accepted write hit an already-written slot.

Behaviour:
- Reset (async, rst_n=0), all outputs and state registers go to 0:
  - out_valid=0, out_word=0, slot_mask=0, err_addr=0, err_dup=0.
  - state=FILL.
  - in_ready goes to 1 after reset is released.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready, so the accumulator keeps accepting while a word drains.
- Decode of an accepted symbol:
  - addr < ADDR_SPAN: slot = addr mod NUM_SLOTS. Write in_data into accumulator slot, set slot_mask[slot].
    - If that bit was already set: overwrite the slot and pulse err_dup next cycle.
  - addr == 2**ADDR_W-1 (31): clear command. slot_mask and accumulator go to 0; in_data is ignored. No effect on a word already in the output register.
  - Otherwise (28..30): symbol dropped, err_addr pulses next cycle, accumulator unchanged.
- State machine:
  - FILL: the accumulator is collecting symbols.
  - When an accepted write makes slot_mask all-ones:
    - Accumulator plus the new symbol is copied into out_word on that clock edge.
    - out_valid=1 the next cycle (1-cycle latency from the last write).
    - Accumulator and slot_mask clear on the same edge.
    - State goes to HOLD.
  - HOLD: out_word is stable while out_valid && !out_ready.
    - out_valid && out_ready: out_valid drops, unless a new word completes on the same edge, in which case out_valid stays 1 and out_word takes the new value.
    - Return to FILL when out_valid drops.
- Backpressure: while out_valid && !out_ready, in_ready=0 and no symbol is consumed.
- Simultaneous events:
  - Clear command and word completion cannot coincide (one symbol per cycle).
  - Accept and output handshake in the same cycle are both honoured.
- Reset asserted mid-word: partial contents are discarded and no word is emitted.
- err pulses are exactly 1 cycle wide, one per offending symbol.

Optional Feature:
- Macro: FIELD_PACKER_STATS_EN.
- Defined: adds two ports.
  - word_count output 16 bits: increments on each out handshake, wraps from 0xFFFF to 0.
  - drop_count output 8 bits: increments on each err_addr event, saturates at 0xFF.
  - Both counters reset to 0 on rst_n.
- Not defined: both ports and their counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package field_pkg holds:
  - the FIELD_W, NUM_SLOTS, ADDR_W and ADDR_SPAN defaults;
  - CLEAR_ADDR (all-ones);
  - the packed-word typedef;
  - the slot-index function (addr mod NUM_SLOTS), used by both this block and the selector.
- One sub-module, field_slot_decode: combinational addr -> {slot one-hot, is_data, is_clear, is_err}.
- Accumulator, FSM and output register stay in field_packer.

Test Plan:
- Fill: write addr 0..6 with data 1..7, out_ready=1 -> one cycle after the 7th write, out_valid=1 and out_word=21'o7654321, slot_mask=0.
- Mapping: write addr 7,15,23,3,11,19,27 with data 5 -> slot_mask bits 0,1,2,3,4,5,6 set in that order. Packed word = 21'o5555555.
- Backpressure: complete a word with out_ready=0 -> in_ready=0 and out_word held stable for 10 cycles. Then raise out_ready together with a write to addr 0 -> word retired, slot_mask=7'b0000001.
- Errors: addr 29 -> err_addr pulses for 1 cycle, slot_mask unchanged. Write addr 2 twice (data 3, then 6) -> err_dup pulses once, slot 2 holds 6.
- Clear: write slots 0..4, send addr 31 -> slot_mask=0. Then fill 0..6 -> the emitted word contains only the post-clear data.
- Reset mid-word: write 4 slots, pulse rst_n low asynchronously -> all outputs 0 immediately and no out_valid afterwards. With FIELD_PACKER_STATS_EN defined, word_count=0.
